// File: rtl/hilo_unit.sv
// hilo_unit -- HI/LO register file and sequencer for the multiply/divide units.
//
// A one-cycle MultStart or DivStart in IDLE raises the matching unit enable
// (MultCtrl/DivCtrl). The FSM then walks IDLE -> LAUNCH -> WAIT -> RELEASE -> IDLE.
// A Done from the selected unit in WAIT commits its result into HI/LO.
// On a divide, Div0 takes priority over DivDone: it raises Div0Exc and HI/LO
// keep their values.
//
// Ports:
//   clock                       rising-edge clock
//   reset                       synchronous, active-high
//   MultStart, DivStart         one-cycle operation requests (mult wins a tie)
//   MultDone, DivDone, Div0     completion / divide-by-zero flags from the units
//   MultHIOut, MultLOOut        64-bit product, high and low halves
//   DivHIOut, DivLOOut          remainder and quotient
//   MultCtrl, DivCtrl           registered level enables to the units
//   HIOut, LOOut                architectural HI and LO registers
//   Busy                        high whenever an operation is in flight
//   OpDone                      one-cycle pulse while the freshly committed HI/LO are visible
//   Div0Exc                     one-cycle divide-by-zero exception pulse
//
// Optional feature (macro HILO_MTX_EN): adds MthiWrite, MtloWrite and WriteData
// for direct HI/LO writes while in IDLE.
module hilo_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        MultStart,
    input  logic        DivStart,
    input  logic        MultDone,
    input  logic        DivDone,
    input  logic        Div0,
    input  logic [31:0] MultHIOut,
    input  logic [31:0] MultLOOut,
    input  logic [31:0] DivHIOut,
    input  logic [31:0] DivLOOut,
`ifdef HILO_MTX_EN
    input  logic        MthiWrite,
    input  logic        MtloWrite,
    input  logic [31:0] WriteData,
`endif
    output logic        MultCtrl,
    output logic        DivCtrl,
    output logic [31:0] HIOut,
    output logic [31:0] LOOut,
    output logic        Busy,
    output logic        OpDone,
    output logic        Div0Exc
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LAUNCH  = 2'd1,
        S_WAIT    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic        op_div, op_div_nxt;        // 0 = mult, 1 = div
    logic        mult_ctrl_nxt, div_ctrl_nxt;
    logic [31:0] hi_nxt, lo_nxt;
    logic        op_done_nxt, div0_exc_nxt;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            op_div   <= 1'b0;
            MultCtrl <= 1'b0;
            DivCtrl  <= 1'b0;
            HIOut    <= '0;
            LOOut    <= '0;
            OpDone   <= 1'b0;
            Div0Exc  <= 1'b0;
        end else begin
            state    <= state_nxt;
            op_div   <= op_div_nxt;
            MultCtrl <= mult_ctrl_nxt;
            DivCtrl  <= div_ctrl_nxt;
            HIOut    <= hi_nxt;
            LOOut    <= lo_nxt;
            OpDone   <= op_done_nxt;
            Div0Exc  <= div0_exc_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        op_div_nxt    = op_div;
        mult_ctrl_nxt = MultCtrl;
        div_ctrl_nxt  = DivCtrl;
        hi_nxt        = HIOut;
        lo_nxt        = LOOut;
        op_done_nxt   = 1'b0;
        div0_exc_nxt  = 1'b0;

        case (state)
            S_IDLE: begin
`ifdef HILO_MTX_EN
                // A write in the same cycle as an accepted start still lands;
                // the later commit simply overwrites it.
                if (MthiWrite) hi_nxt = WriteData;
                if (MtloWrite) lo_nxt = WriteData;
`endif
                if (MultStart) begin
                    op_div_nxt    = 1'b0;
                    mult_ctrl_nxt = 1'b1;
                    state_nxt     = S_LAUNCH;
                end else if (DivStart) begin
                    op_div_nxt    = 1'b1;
                    div_ctrl_nxt  = 1'b1;
                    state_nxt     = S_LAUNCH;
                end
            end
            // One dead cycle: a Done still high from the previous operation
            // must not be mistaken for completion of this one.
            S_LAUNCH: state_nxt = S_WAIT;
            S_WAIT: begin
                if (!op_div) begin
                    if (MultDone) begin
                        hi_nxt        = MultHIOut;
                        lo_nxt        = MultLOOut;
                        op_done_nxt   = 1'b1;
                        mult_ctrl_nxt = 1'b0;
                        state_nxt     = S_RELEASE;
                    end
                end else if (Div0) begin
                    div0_exc_nxt  = 1'b1;
                    div_ctrl_nxt  = 1'b0;
                    state_nxt     = S_RELEASE;
                end else if (DivDone) begin
                    hi_nxt        = DivHIOut;
                    lo_nxt        = DivLOOut;
                    op_done_nxt   = 1'b1;
                    div_ctrl_nxt  = 1'b0;
                    state_nxt     = S_RELEASE;
                end
            end
            // Enables stay low for this cycle so the units see a clean re-arm.
            S_RELEASE: begin
                mult_ctrl_nxt = 1'b0;
                div_ctrl_nxt  = 1'b0;
                state_nxt     = S_IDLE;
            end
            default: begin
                mult_ctrl_nxt = 1'b0;
                div_ctrl_nxt  = 1'b0;
                state_nxt     = S_IDLE;
            end
        endcase
    end

    assign Busy = (state != S_IDLE);

endmodule

// File: doc/hilo_unit.md
HILO_UNIT -- requirements
Module: hilo_unit

Interface
REQ-001 SHALL have ports: clock  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high.
REQ-003 SHALL have ports: MultStart  in  1  one-cycle request for a multiply (mult).
REQ-004 SHALL have ports: DivStart  in  1  one-cycle request for a divide (div).
REQ-005 SHALL have ports: MultDone  in  1  completion flag from the multiplier.
REQ-006 SHALL have ports: DivDone  in  1  completion flag from the divider.
REQ-007 SHALL have ports: Div0  in  1  divide-by-zero flag from the divider.
REQ-008 SHALL have ports: MultHIOut, MultLOOut  in  32 each  multiplier result.
REQ-009 SHALL have ports: DivHIOut, DivLOOut  in  32 each  divider remainder and quotient.
REQ-010 SHALL have ports: MultCtrl, DivCtrl  out  1 each  registered level enables to the multiplier and divider.
REQ-011 SHALL have ports: HIOut, LOOut  out  32 each  architectural HI and LO registers.
REQ-012 SHALL have ports: Busy  out  1  operation in flight; the control unit stalls on it.
REQ-013 SHALL have ports: OpDone  out  1  one-cycle pulse when HI and LO are committed.
REQ-014 SHALL have ports: Div0Exc  out  1  one-cycle divide-by-zero exception pulse.
REQ-015 SHALL have ports (present only with HILO_MTX_EN): MthiWrite, MtloWrite  in  1 each; WriteData  in  32.

Function
REQ-016 SHALL implement the FSM IDLE -> LAUNCH -> WAIT -> RELEASE -> IDLE, with a 1-bit register recording whether the operation is mult or div.
REQ-017 In IDLE, MultStart SHALL set op=mult, drive MultCtrl=1 and go to LAUNCH; DivStart SHALL set op=div, drive DivCtrl=1 and go to LAUNCH.
REQ-018 If MultStart and DivStart are high together, SHALL accept MultStart and ignore DivStart.
REQ-019 Outside IDLE, SHALL ignore MultStart and DivStart.
REQ-020 LAUNCH SHALL last exactly one cycle and SHALL ignore all Done/Div0 inputs, to reject a stale Done from the previous operation.
REQ-021 In WAIT with op=mult, MultDone=1 SHALL load HIOut<=MultHIOut and LOOut<=MultLOOut, pulse OpDone, clear MultCtrl and go to RELEASE.
REQ-022 In WAIT with op=div, Div0=1 SHALL take priority over DivDone: pulse Div0Exc, leave HI and LO unchanged, clear DivCtrl and go to RELEASE.
REQ-023 In WAIT with op=div, DivDone=1 and Div0=0 SHALL load HIOut<=DivHIOut (remainder) and LOOut<=DivLOOut (quotient), pulse OpDone, clear DivCtrl and go to RELEASE.
REQ-024 RELEASE SHALL hold MultCtrl=0 and DivCtrl=0 for exactly one cycle so the units re-arm, then return to IDLE.
REQ-025 Busy SHALL be high in LAUNCH, WAIT and RELEASE, and low only in IDLE.
REQ-026 WAIT SHALL have no timeout; it waits indefinitely for Done.
REQ-027 Latency: HI/LO SHALL commit at the 35th rising edge after the edge that samples MultStart.
REQ-028 Latency: for a div of 7/2, HI/LO SHALL commit at the 6th rising edge after the edge that samples DivStart.
REQ-029 Busy SHALL fall one edge after commit in both cases.
REQ-030 At most one of MultCtrl and DivCtrl SHALL be high at any time.

Reset
REQ-031 When reset=1 at an edge, including mid-operation, SHALL go to IDLE and set MultCtrl=0, DivCtrl=0, HIOut=0, LOOut=0, Busy=0, OpDone=0, Div0Exc=0, op=mult.
REQ-032 Reset SHALL override every start and write input in the same cycle.

Configuration
REQ-033 Macro HILO_MTX_EN defined: in IDLE, MthiWrite SHALL load HIOut<=WriteData and MtloWrite SHALL load LOOut<=WriteData.
REQ-034 With HILO_MTX_EN, both writes in one cycle SHALL update both registers.
REQ-035 With HILO_MTX_EN, a write coincident with an accepted start SHALL still take effect and be overwritten at commit.
REQ-036 With HILO_MTX_EN, writes outside IDLE SHALL be ignored.
REQ-037 Macro HILO_MTX_EN undefined: the MthiWrite, MtloWrite and WriteData ports SHALL be absent, and HI and LO SHALL change only on commit and reset.

Verification
REQ-038 Mult: A=3, B=-5, MultStart pulse -> commit at edge 35 with HIOut=0xFFFFFFFF, LOOut=0xFFFFFFF1; OpDone pulse 1 cycle; Busy low at edge 36.
REQ-039 Div: A=7, B=2 -> HIOut=1, LOOut=3 at edge 6; DivCtrl low for 1 cycle afterwards.
REQ-040 Div: A=-7, B=2 -> HIOut=0xFFFFFFFF (-1), LOOut=0xFFFFFFFD (-3).
REQ-041 Div: A=5, B=0 -> Div0Exc pulse at edge 2; HI/LO keep their previous values; no OpDone pulse.
REQ-042 Same-cycle MultStart and DivStart -> only MultCtrl rises. A DivStart during Busy is ignored. A back-to-back mult issued right after IDLE returns ignores the stale MultDone during LAUNCH.
REQ-043 Reset at edge 10 of a mult -> all outputs zero next cycle; a subsequent mult completes correctly. With HILO_MTX_EN: MthiWrite with 0xDEADBEEF in IDLE -> HIOut=0xDEADBEEF; the same write while Busy -> HIOut unchanged.
